// File: rtl/divider.sv
// Sequential radix-2 restoring divider with op_start/op_clear/op_done handshake.
// Optional feature macro: DIVIDER_SIGNED_EN (two's complement operands, truncating division).
module divider #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             op_start,
   input  logic             op_clear,
   output logic             op_done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      INIT   = 2'b00,
      DIVIDE = 2'b01,
      DONE   = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] p_q;      // partial remainder
   logic [WIDTH-1:0] a_q;      // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] d_q;      // divisor magnitude
   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   p_trial;
   logic [WIDTH-1:0] dend_abs;
   logic [WIDTH-1:0] dsor_abs;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;

   // One restoring iteration: shift in next dividend bit, trial-subtract divisor
   assign p_shift = {p_q, a_q[WIDTH-1]};
   assign p_trial = p_shift - {1'b0, d_q};

`ifdef DIVIDER_SIGNED_EN
   logic q_neg_q;
   logic r_neg_q;

   // Operate on magnitudes; the signs are reapplied on the final DIVIDE edge
   assign dend_abs = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
   assign dsor_abs = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
   assign q_res    = q_neg_q ? WIDTH'(-a_q) : a_q;
   assign r_res    = r_neg_q ? WIDTH'(-p_q) : p_q;

   // Result signs: quotient negative on differing signs, remainder follows dividend
   always_ff @(posedge clk) begin
      if (reset || op_clear) begin
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (state_q == INIT && op_start) begin
         q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_neg_q <= dividend[WIDTH-1];
      end
   end
`else
   assign dend_abs = dividend;
   assign dsor_abs = divisor;
   assign q_res    = a_q;
   assign r_res    = p_q;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= INIT;
      else       state_q <= state_d;
   end

   // Next-state logic; op_clear returns to INIT from anywhere, illegal code recovers
   always_comb begin
      state_d = INIT;
      case (state_q)
         INIT: begin
            if (op_start) state_d = (divisor == '0) ? DONE : DIVIDE;
         end
         DIVIDE: begin
            state_d = (cnt_q == CW'(WIDTH)) ? DONE : DIVIDE;
         end
         DONE:    state_d = DONE;
         default: state_d = INIT;
      endcase
      if (op_clear) state_d = INIT;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (reset || op_clear) begin
         cnt_q       <= '0;
         p_q         <= '0;
         a_q         <= '0;
         d_q         <= '0;
         op_done     <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            INIT: begin
               if (op_start) begin
                  cnt_q <= '0;
                  p_q   <= '0;
                  a_q   <= dend_abs;
                  d_q   <= dsor_abs;
                  if (divisor == '0) begin
                     op_done     <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            DIVIDE: begin
               if (cnt_q == CW'(WIDTH)) begin
                  op_done   <= 1'b1;
                  quotient  <= q_res;
                  remainder <= r_res;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  if (!p_trial[WIDTH]) begin
                     p_q <= p_trial[WIDTH-1:0];
                     a_q <= {a_q[WIDTH-2:0], 1'b1};
                  end else begin
                     p_q <= p_shift[WIDTH-1:0];
                     a_q <= {a_q[WIDTH-2:0], 1'b0};
                  end
               end
            end
            DONE: begin
            end
            default: begin
               op_done     <= 1'b0;
               quotient    <= '0;
               remainder   <= '0;
               div_by_zero <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider (WIDTH=64).
module tb_divider;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         op_start;
   logic         op_clear;
   logic         op_done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks   = 0;
   int failures = 0;

   divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .dividend    (dividend),
      .divisor     (divisor),
      .op_start    (op_start),
      .op_clear    (op_clear),
      .op_done     (op_done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands with op_start for exactly one edge
   task automatic start_op(input logic [W-1:0] dd, input logic [W-1:0] ds);
      dividend = dd;
      divisor  = ds;
      op_start = 1'b1;
      tick();
      op_start = 1'b0;
   endtask

   task automatic clear_op();
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
   endtask

   // Count edges after the start edge until op_done, bounded
   task automatic wait_done(output int edges);
      edges = 0;
      while (!op_done && edges < 200) begin
         tick();
         edges++;
      end
      if (!op_done) check("timeout", W'(0), W'(1));
   endtask

   task automatic run_div(input string tag, input logic [W-1:0] dd, input logic [W-1:0] ds,
                          input logic [W-1:0] eq, input logic [W-1:0] er);
      int e;
      start_op(dd, ds);
      wait_done(e);
      check({tag, "_lat"}, W'(e), W'(65));
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, er);
      check({tag, "_dbz"}, W'(div_by_zero), W'(0));
      clear_op();
   endtask

   initial begin
      int e;
      reset    = 1'b1;
      dividend = '0;
      divisor  = '0;
      op_start = 1'b0;
      op_clear = 1'b0;
      tick();
      tick();
      check("rst_done", W'(op_done), W'(0));
      check("rst_q", quotient, W'(0));
      check("rst_r", remainder, W'(0));
      check("rst_dbz", W'(div_by_zero), W'(0));
      reset = 1'b0;
      tick();

      // Basic vectors, valid in either signedness
      run_div("d100_7", W'(100), W'(7), W'(14), W'(2));
      run_div("dmax_1", {W{1'b1}}, W'(1), {W{1'b1}}, W'(0));
      run_div("d5_9", W'(5), W'(9), W'(0), W'(5));

      // Divide by zero completes on the start edge
      start_op(W'(123), W'(0));
      check("dz_done", W'(op_done), W'(1));
      check("dz_flag", W'(div_by_zero), W'(1));
      check("dz_q", quotient, {W{1'b1}});
      check("dz_r", remainder, W'(123));
      clear_op();
      check("dz_clr_done", W'(op_done), W'(0));
      check("dz_clr_flag", W'(div_by_zero), W'(0));

      // Abort mid-operation, then a fresh division
      start_op(W'(1000), W'(3));
      dividend = W'(55);
      divisor  = W'(11);
      for (int i = 0; i < 29; i++) tick();
      check("mid_q", quotient, W'(0));
      check("mid_done", W'(op_done), W'(0));
      clear_op();
      check("abort_done", W'(op_done), W'(0));
      check("abort_q", quotient, W'(0));
      check("abort_r", remainder, W'(0));
      for (int i = 0; i < 70; i++) tick();
      check("abort_idle", W'(op_done), W'(0));
      run_div("d9_3", W'(9), W'(3), W'(3), W'(0));

      // DONE ignores op_start and operand changes
      start_op(W'(9), W'(3));
      wait_done(e);
      op_start = 1'b1;
      dividend = W'(50);
      divisor  = W'(5);
      tick();
      tick();
      tick();
      check("hold_done", W'(op_done), W'(1));
      check("hold_q", quotient, W'(3));
      check("hold_r", remainder, W'(0));
      // op_clear wins over op_start on the same edge
      op_clear = 1'b1;
      tick();
      op_clear = 1'b0;
      check("prio_done", W'(op_done), W'(0));
      check("prio_q", quotient, W'(0));
      tick();
      op_start = 1'b0;
      wait_done(e);
      check("restart_lat", W'(e), W'(65));
      check("restart_q", quotient, W'(10));
      check("restart_r", remainder, W'(0));
      clear_op();

      // Reset during DIVIDE
      start_op(W'(77), W'(4));
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rdiv_done", W'(op_done), W'(0));
      check("rdiv_q", quotient, W'(0));
      check("rdiv_r", remainder, W'(0));
      for (int i = 0; i < 70; i++) tick();
      check("rdiv_idle", W'(op_done), W'(0));

`ifdef DIVIDER_SIGNED_EN
      run_div("sm7_2", -W'(7), W'(2), -W'(3), -W'(1));
      run_div("s7_m2", W'(7), -W'(2), -W'(3), W'(1));
      run_div("smin_m1", {1'b1, {(W-1){1'b0}}}, {W{1'b1}}, {1'b1, {(W-1){1'b0}}}, W'(0));
      run_div("sm1_2", {W{1'b1}}, W'(2), W'(0), {W{1'b1}});
      start_op(-W'(5), W'(0));
      check("sdz_flag", W'(div_by_zero), W'(1));
      check("sdz_q", quotient, {W{1'b1}});
      check("sdz_r", remainder, -W'(5));
      clear_op();
`else
      run_div("umax_2", {W{1'b1}}, W'(2), {1'b0, {(W-1){1'b1}}}, W'(1));
      run_div("ubig", {1'b1, {(W-1){1'b0}}}, W'(3), W'(64'h2AAAAAAAAAAAAAAA), W'(2));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
